// File: rtl/vga_text_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_text_pkg
//  Description : Shared constants and types for the VGA text overlay:
//                glyph geometry, attribute layout, CGA palette, FSM states
//                and the fixed video pipeline latency.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_text_pkg;

    localparam int FONT_W   = 8;
    localparam int FONT_H   = 16;
    localparam int PIPE_LAT = 3;

    // Attribute byte of a character cell: background in the high nibble
    typedef struct packed {
        logic [3:0] bg;
        logic [3:0] fg;
    } attr_t;

    // Write-port / clear-engine controller states
    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_CLEAR = 1'b1;

    // 16-entry 4:4:4 palette in CGA order, entry 0 in the least significant slot
    localparam logic [16*12-1:0] c_PALETTE = {
        12'hFFF, 12'hFF5, 12'hF5F, 12'hF55,
        12'h5FF, 12'h5F5, 12'h55F, 12'h555,
        12'hAAA, 12'hA50, 12'hA0A, 12'hA00,
        12'h0AA, 12'h0A0, 12'h00A, 12'h000
    };

    function automatic logic [11:0] palette(input logic [3:0] idx);
        return c_PALETTE[idx*12 +: 12];
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_text_font_rom.sv
`default_nettype none
// ============================================================================
//  Module      : vga_text_font_rom
//  Description : 4096 x 8 glyph ROM addressed by {char, line}, registered
//                output (one cycle latency). Holds the glyphs used by the
//                overlay; every other code point renders as blank.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_text_font_rom (
    input  logic        clk,
    input  logic [11:0] addr,
    output logic [7:0]  data
);

    logic [7:0] w_row;

    // Glyph table lookup: 'A' (0x41) and the full block (0xDB)
    always_comb begin
        w_row = 8'h00;
        case (addr)
            12'h412: w_row = 8'h10;
            12'h413: w_row = 8'h38;
            12'h414: w_row = 8'h6C;
            12'h415, 12'h416, 12'h418,
            12'h419, 12'h41A, 12'h41B: w_row = 8'hC6;
            12'h417: w_row = 8'hFE;
            default: w_row = 8'h00;
        endcase
        if (addr[11:4] == 8'hDB) begin
            w_row = 8'hFF;
        end
    end

    // Registered ROM output
    always_ff @(posedge clk) begin
        data <= w_row;
    end

endmodule
`default_nettype wire

// File: rtl/vga_text_overlay.sv
`default_nettype none
// ============================================================================
//  Module      : vga_text_overlay
//  Description : 128x48 text-mode renderer (8x16 glyphs, 1024x768) driven by
//                an external VGA timing generator. Three-stage pipeline:
//                char RAM -> font ROM -> palette, with syncs delayed to match.
//                Valid/ready write port plus a screen clear engine.
//                Optional blinking block cursor: define VGA_TEXT_CURSOR_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_text_overlay
    import vga_text_pkg::*;
#(
    parameter int          W_X       = 11,
    parameter int          W_Y       = 10,
    parameter int          COLS      = 128,
    parameter int          ROWS      = 48,
    parameter int          W_RED     = 4,
    parameter int          W_GREEN   = 4,
    parameter int          W_BLUE    = 4,
    parameter logic [15:0] FILL_WORD = 16'h0720
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [W_X-1:0]     hpos,
    input  logic [W_Y-1:0]     vpos,
    input  logic               display_on,
    input  logic               hsync_in,
    input  logic               vsync_in,
    output logic [W_RED-1:0]   red,
    output logic [W_GREEN-1:0] green,
    output logic [W_BLUE-1:0]  blue,
    output logic               hsync,
    output logic               vsync,
    output logic               display_on_out,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [6:0]         wr_col,
    input  logic [5:0]         wr_row,
    input  logic [15:0]        wr_data,
    output logic               wr_err,
    input  logic               clr_req,
    output logic               clr_busy
`ifdef VGA_TEXT_CURSOR_EN
    ,
    input  logic [6:0]         cur_col,
    input  logic [5:0]         cur_row
`endif
);

    localparam int c_LINE_W = $clog2(FONT_H);
    localparam int c_BIT_W  = $clog2(FONT_W);
    localparam int c_COL_W  = $clog2(COLS);
    localparam int c_ROW_W  = $clog2(ROWS);
    localparam int c_ADDR_W = c_ROW_W + c_COL_W;
    localparam int c_DEPTH  = ROWS * COLS;
    localparam logic [c_ADDR_W-1:0] c_LAST_ADDR = c_ADDR_W'(c_DEPTH - 1);

    // ------------------------------------------------------------------
    // Controller state and character RAM
    // ------------------------------------------------------------------
    logic [0:0]          r_state;
    logic [c_ADDR_W-1:0] r_clr_addr;
    logic                r_wr_err;
    logic [15:0]         r_ram [c_DEPTH];

    logic                w_wr_fire;
    logic                w_wr_in_range;
    logic                w_ram_we;
    logic [c_ADDR_W-1:0] w_ram_waddr;
    logic [15:0]         w_ram_wdata;

    assign wr_ready      = (r_state == c_ST_IDLE);
    assign clr_busy      = (r_state == c_ST_CLEAR);
    assign wr_err        = r_wr_err;
    assign w_wr_fire     = wr_valid && wr_ready;
    assign w_wr_in_range = (int'(wr_row) < ROWS) && (int'(wr_col) < COLS);

    // Single RAM write port shared by the clear engine and the host port
    always_comb begin
        w_ram_we    = 1'b0;
        w_ram_waddr = r_clr_addr;
        w_ram_wdata = FILL_WORD;
        if (!rst) begin
            if (r_state == c_ST_CLEAR) begin
                w_ram_we = 1'b1;
            end else if (w_wr_fire && w_wr_in_range) begin
                w_ram_we    = 1'b1;
                w_ram_waddr = {wr_row, wr_col};
                w_ram_wdata = wr_data;
            end
        end
    end

    // Controller: idle/clear sequencing and sticky out-of-range flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_clr_addr <= '0;
            r_wr_err   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (clr_req) begin
                        r_state    <= c_ST_CLEAR;
                        r_clr_addr <= '0;
                    end
                end
                c_ST_CLEAR: begin
                    if (r_clr_addr == c_LAST_ADDR) begin
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_clr_addr <= r_clr_addr + 1'b1;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
            if (w_wr_fire && !w_wr_in_range) begin
                r_wr_err <= 1'b1;
            end
        end
    end

    // RAM write port (contents deliberately not reset)
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_ram[w_ram_waddr] <= w_ram_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Video pipeline
    // ------------------------------------------------------------------
    logic [W_X-c_BIT_W-1:0]  w_cell_x;
    logic [W_Y-c_LINE_W-1:0] w_cell_y;
    logic                    w_rd_ok;
    logic [c_ADDR_W-1:0]     w_rd_addr;

    // Blanking coordinates fall outside the text area; they read cell 0
    // and are masked later by the delayed display_on.
    assign w_cell_x  = hpos[W_X-1:c_BIT_W];
    assign w_cell_y  = vpos[W_Y-1:c_LINE_W];
    assign w_rd_ok   = (int'(w_cell_x) < COLS) && (int'(w_cell_y) < ROWS);
    assign w_rd_addr = w_rd_ok ? {w_cell_y[c_ROW_W-1:0], w_cell_x[c_COL_W-1:0]} : '0;

    logic [15:0]         r_s1_data;
    logic [c_LINE_W-1:0] r_s1_line;
    logic [c_BIT_W-1:0]  r_s1_bit;
    logic [7:0]          r_font_byte;
    attr_t               r_s2_attr;
    logic [c_BIT_W-1:0]  r_s2_bit;
    logic [PIPE_LAT-1:0] r_de_pipe;
    logic [PIPE_LAT-1:0] r_hs_pipe;
    logic [PIPE_LAT-1:0] r_vs_pipe;

    // S1: character RAM read; old data is returned on a same-address write
    always_ff @(posedge clk) begin
        r_s1_data <= r_ram[w_rd_addr];
    end

    // S1/S2: carry glyph line, bit index and attribute alongside the reads
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_line <= '0;
            r_s1_bit  <= '0;
            r_s2_attr <= '0;
            r_s2_bit  <= '0;
        end else begin
            r_s1_line <= vpos[c_LINE_W-1:0];
            r_s1_bit  <= hpos[c_BIT_W-1:0];
            r_s2_attr <= attr_t'(r_s1_data[15:8]);
            r_s2_bit  <= r_s1_bit;
        end
    end

    // S2: glyph row fetch
    vga_text_font_rom u_font_rom (
        .clk  (clk),
        .addr ({r_s1_data[7:0], r_s1_line}),
        .data (r_font_byte)
    );

    // Sync and display-enable delay line matching the pixel pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            r_de_pipe <= '0;
            r_hs_pipe <= '0;
            r_vs_pipe <= '0;
        end else begin
            r_de_pipe <= {r_de_pipe[PIPE_LAT-2:0], display_on};
            r_hs_pipe <= {r_hs_pipe[PIPE_LAT-2:0], hsync_in};
            r_vs_pipe <= {r_vs_pipe[PIPE_LAT-2:0], vsync_in};
        end
    end

    assign display_on_out = r_de_pipe[PIPE_LAT-1];
    assign hsync          = r_hs_pipe[PIPE_LAT-1];
    assign vsync          = r_vs_pipe[PIPE_LAT-1];

    logic w_cursor_on;

`ifdef VGA_TEXT_CURSOR_EN
    logic [5:0]          r_frame_cnt;
    logic                r_vs_prev;
    logic [c_COL_W-1:0]  r_s1_col;
    logic [c_ROW_W-1:0]  r_s1_row;
    logic [c_COL_W-1:0]  r_s2_col;
    logic [c_ROW_W-1:0]  r_s2_row;
    logic [c_LINE_W-1:0] r_s2_line;

    // Frame counter advanced on each vsync_in rising edge; bit 5 is the blink phase
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt <= '0;
            r_vs_prev   <= 1'b0;
        end else begin
            r_vs_prev <= vsync_in;
            if (vsync_in && !r_vs_prev) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    // Cell position travels with the pixel so S3 can compare it to the cursor
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_col  <= '0;
            r_s1_row  <= '0;
            r_s2_col  <= '0;
            r_s2_row  <= '0;
            r_s2_line <= '0;
        end else begin
            r_s1_col  <= w_rd_addr[c_COL_W-1:0];
            r_s1_row  <= w_rd_addr[c_ADDR_W-1:c_COL_W];
            r_s2_col  <= r_s1_col;
            r_s2_row  <= r_s1_row;
            r_s2_line <= r_s1_line;
        end
    end

    assign w_cursor_on = r_frame_cnt[5] && (r_s2_row == cur_row) && (r_s2_col == cur_col)
                         && (r_s2_line >= c_LINE_W'(FONT_H - 2));
`else
    assign w_cursor_on = 1'b0;
`endif

    logic [c_BIT_W-1:0] w_bit_sel;
    logic               w_pix_on;
    logic [11:0]        w_colour;

    // Glyph MSB is the leftmost pixel of the cell
    assign w_bit_sel = c_BIT_W'(FONT_W - 1) - r_s2_bit;
    assign w_pix_on  = r_font_byte[w_bit_sel] || w_cursor_on;
    assign w_colour  = palette(w_pix_on ? r_s2_attr.fg : r_s2_attr.bg);

    // S3: palette lookup, blanked outside active video
    always_ff @(posedge clk) begin
        if (rst || !r_de_pipe[PIPE_LAT-2]) begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end else begin
            red   <= w_colour[11:8];
            green <= w_colour[7:4];
            blue  <= w_colour[3:0];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_text_overlay.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_text_overlay
//  Description : Directed self-checking bench for vga_text_overlay: reset,
//                sync delay, glyph rendering, out-of-range writes, screen
//                clear and reset during clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_text_overlay;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] hpos = '0;
    logic [9:0]  vpos = '0;
    logic        display_on = 1'b0;
    logic        hsync_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic [3:0]  red, green, blue;
    logic        hsync, vsync, display_on_out;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [6:0]  wr_col = '0;
    logic [5:0]  wr_row = '0;
    logic [15:0] wr_data = '0;
    logic        wr_err;
    logic        clr_req = 1'b0;
    logic        clr_busy;
`ifdef VGA_TEXT_CURSOR_EN
    logic [6:0]  cur_col = 7'd0;
    logic [5:0]  cur_row = 6'd63;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [14:0] pe [3];
    bit          pc [3];
    string       pt [3];

    always #5 clk = ~clk;

    vga_text_overlay dut (
        .clk            (clk),
        .rst            (rst),
        .hpos           (hpos),
        .vpos           (vpos),
        .display_on     (display_on),
        .hsync_in       (hsync_in),
        .vsync_in       (vsync_in),
        .red            (red),
        .green          (green),
        .blue           (blue),
        .hsync          (hsync),
        .vsync          (vsync),
        .display_on_out (display_on_out),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_col         (wr_col),
        .wr_row         (wr_row),
        .wr_data        (wr_data),
        .wr_err         (wr_err),
        .clr_req        (clr_req),
        .clr_busy       (clr_busy)
`ifdef VGA_TEXT_CURSOR_EN
        ,
        .cur_col        (cur_col),
        .cur_row        (cur_row)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // 'A' glyph rows, drawn by hand
    function automatic logic [7:0] glyph_a(input int line);
        case (line)
            2:                   return 8'h10;
            3:                   return 8'h38;
            4:                   return 8'h6C;
            5, 6, 8, 9, 10, 11:  return 8'hC6;
            7:                   return 8'hFE;
            default:             return 8'h00;
        endcase
    endfunction

    function automatic logic [11:0] a_pix(input int line, input int b,
                                          input logic [11:0] fg_c, input logic [11:0] bg_c);
        logic [7:0] g;
        g = glyph_a(line);
        return g[7-b] ? fg_c : bg_c;
    endfunction

    // Apply one pixel; compare the outputs against the pixel applied three clocks earlier
    task automatic vid(input int x, input int y, input logic de, input logic hs, input logic vs,
                       input logic [11:0] rgb, input bit check, input string tag);
        hpos = 11'(x);
        vpos = 10'(y);
        display_on = de;
        hsync_in = hs;
        vsync_in = vs;
        pe[2] = pe[1]; pc[2] = pc[1]; pt[2] = pt[1];
        pe[1] = pe[0]; pc[1] = pc[0]; pt[1] = pt[0];
        pe[0] = {de, hs, vs, (de ? rgb : 12'h000)};
        pc[0] = check;
        pt[0] = tag;
        tick();
        if (pc[2]) begin
            chk(pt[2], 32'({display_on_out, hsync, vsync, red, green, blue}), 32'(pe[2]));
        end
    endtask

    task automatic probe(input int x, input int y, input logic [11:0] rgb, input string tag);
        vid(x, y, 1'b1, 1'b0, 1'b0, rgb, 1'b1, tag);
        vid(0, 0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, "idle");
        vid(0, 0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, "idle");
    endtask

    task automatic wr(input int col, input int row, input logic [15:0] d);
        int n;
        wr_col = 7'(col);
        wr_row = 6'(row);
        wr_data = d;
        wr_valid = 1'b1;
        n = 0;
        while (!wr_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk("wr_ready_timeout", 32'(n), 32'(0));
        tick();
        wr_valid = 1'b0;
    endtask

    initial begin
        int busy;
        int ready_in_clear;
        for (int i = 0; i < 3; i++) begin
            pc[i] = 1'b0;
            pe[i] = '0;
            pt[i] = "idle";
        end

        // Reset with live inputs: everything downstream stays cleared
        rst = 1'b1; display_on = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
        repeat (4) tick();
        chk("rst_rgb",   32'({red, green, blue}), 32'(0));
        chk("rst_syncs", 32'({hsync, vsync, display_on_out}), 32'(0));
        chk("rst_busy",  32'(clr_busy), 32'(0));
        chk("rst_err",   32'(wr_err), 32'(0));
        display_on = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
        rst = 1'b0;
        tick();
        chk("idle_ready", 32'(wr_ready), 32'(1));

        // Seed a few cells, confirm they render, then clear the screen
        wr(0, 0, 16'h1F41);
        wr(50, 0, 16'h1F41);
        wr(112, 46, 16'h1F41);
        wr(127, 47, 16'h1F41);
        probe(0, 7, 12'hFFF, "pre_clr_cell0");
        probe(896, 743, 12'hFFF, "pre_clr_cell6000");

        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        chk("clr_busy_start", 32'(clr_busy), 32'(1));
        busy = 0;
        ready_in_clear = 0;
        while (clr_busy && busy < 7000) begin
            if (wr_ready) ready_in_clear++;
            clr_req = (busy == 3000);
            tick();
            busy++;
        end
        clr_req = 1'b0;
        chk("clr_busy_cycles", 32'(busy), 32'(6144));
        chk("wr_ready_in_clear", 32'(ready_in_clear), 32'(0));
        chk("idle_after_clr", 32'(wr_ready), 32'(1));
        probe(0, 7, 12'h000, "clr_cell0");
        probe(400, 7, 12'h000, "clr_cell50");
        probe(896, 743, 12'h000, "clr_cell6000");
        probe(1016, 759, 12'h000, "clr_cell6143");

        // Sync / enable delay on a blank cell
        for (int i = 0; i < 12; i++) begin
            vid(800, 400, 1'(i % 2), 1'((i / 2) % 2), 1'((i / 3) % 2), 12'h000, 1'b1, "sync_delay");
        end
        vid(0, 0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, "idle");
        vid(0, 0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, "idle");

        // Full glyph scan of 'A' fg F / bg 1, plus first pixel of the blank neighbour
        wr(0, 0, 16'h1F41);
        for (int y = 0; y < 16; y++) begin
            for (int x = 0; x < 9; x++) begin
                vid(x, y, 1'b1, 1'b0, 1'b0,
                    (x < 8) ? a_pix(y, x, 12'hFFF, 12'h00A) : 12'h000, 1'b1, "glyph_a");
            end
        end
        vid(0, 0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, "idle");
        vid(0, 0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, "idle");

        // Different attribute: fg E (FF5), bg 4 (A00)
        wr(1, 0, 16'h4E41);
        probe(8, 7, 12'hFF5, "attr_fg_l7");
        probe(15, 7, 12'hA00, "attr_bg_l7");
        probe(11, 2, 12'hFF5, "attr_fg_l2");
        probe(8, 0, 12'hA00, "attr_bg_l0");

        // Out-of-range row: accepted, not written, sticky error
        chk("err_before", 32'(wr_err), 32'(0));
        wr(5, 48, 16'h1F41);
        chk("err_set", 32'(wr_err), 32'(1));
        probe(40, 7, 12'h000, "oor_cell_r0c5");
        probe(40, 759, 12'h000, "oor_cell_r47c5");
        repeat (20) tick();
        chk("err_sticky", 32'(wr_err), 32'(1));

        // Reset in the middle of a clear that starts together with a write
        wr(50, 0, 16'h1F41);
        wr(112, 46, 16'h1F41);
        wr_col = 7'd127; wr_row = 6'd47; wr_data = 16'h1F41;
        wr_valid = 1'b1; clr_req = 1'b1;
        tick();
        wr_valid = 1'b0; clr_req = 1'b0;
        chk("clr_with_write", 32'(clr_busy), 32'(1));
        repeat (100) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_busy",  32'(clr_busy), 32'(0));
        chk("rst_mid_ready", 32'(wr_ready), 32'(1));
        chk("rst_mid_err",   32'(wr_err), 32'(0));
        probe(0, 7, 12'h000, "part_cell0");
        probe(8, 7, 12'h000, "part_cell1");
        probe(400, 7, 12'h000, "part_cell50");
        probe(896, 743, 12'hFFF, "part_cell6000");
        probe(1016, 759, 12'hFFF, "part_cell6143");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
